// File: rtl/riscv_single_cycle.sv
// Single-cycle RV32I-subset core (R-type add/sub/and/or, lw, sw, beq).
// Instruction memory, register file and data memory are all internal.

module instruction_memory #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic                     i_load_en,
  input  logic [$clog2(DEPTH)-1:0] i_load_addr,
  input  logic [31:0]              i_load_data,
  output logic [31:0]              o_rdata
);
  logic [31:0] mem [0:DEPTH-1];

  // Program download port; never cleared by reset.
  always_ff @(posedge clk) begin
    if (i_load_en) mem[i_load_addr] <= i_load_data;
  end

  assign o_rdata = mem[i_addr];
endmodule

module regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] rddata,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data
);
  logic [XLEN-1:0] r_regs [0:31];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_rd != 5'd0)) begin
      r_regs[i_rd] <= rddata;
    end
  end

  assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : r_regs[i_rs1];
  assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : r_regs[i_rs2];
endmodule

module riscv_single_cycle #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64,
  parameter int XLEN       = 32
) (
  input logic clk,
  input logic rst
);
  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_ctl_e;

  logic [XLEN-1:0] PC;
  logic [31:0]     instruction;
  logic            branch, memread, memtoreg, memwrite, alusrc, regwrite, aluz;
  logic [1:0]      aluop;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_funct7_5;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_alu_b, w_alu_res;
  logic [XLEN-1:0] w_dmem_rdata, w_rddata, w_pc_next;
  logic [DA-1:0]   w_dmem_addr;
  alu_ctl_e        w_alu_ctl;
  logic [XLEN-1:0] r_dmem [0:DMEM_DEPTH-1];

  instruction_memory #(.DEPTH(IMEM_DEPTH)) instruction_memory (
    .clk         (clk),
    .i_addr      (PC[IA+1:2]),
    .i_load_en   (1'b0),
    .i_load_addr ('0),
    .i_load_data (32'd0),
    .o_rdata     (instruction)
  );

  assign w_opcode   = instruction[6:0];
  assign w_funct3   = instruction[14:12];
  assign w_funct7_5 = instruction[30];

  always_comb begin
    branch   = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    aluop    = 2'b00;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin aluop = 2'b10; regwrite = 1'b1; end
      OP_LW:    begin memread = 1'b1; memtoreg = 1'b1; alusrc = 1'b1; regwrite = 1'b1; end
      OP_SW:    begin memwrite = 1'b1; alusrc = 1'b1; end
      OP_BEQ:   begin branch = 1'b1; aluop = 2'b01; end
      default:  ;
    endcase
  end

  assign w_imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
  assign w_imm_s = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign w_imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
  assign w_imm   = (w_opcode == OP_SW) ? w_imm_s : w_imm_i;

  regfile #(.XLEN(XLEN)) rf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (regwrite),
    .i_rs1      (instruction[19:15]),
    .i_rs2      (instruction[24:20]),
    .i_rd       (instruction[11:7]),
    .rddata     (w_rddata),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data)
  );

  always_comb begin
    w_alu_ctl = ALU_ADD;
    case (aluop)
      2'b01: w_alu_ctl = ALU_SUB;
      2'b10: begin
        case ({w_funct7_5, w_funct3})
          4'b1000: w_alu_ctl = ALU_SUB;
          4'b0111: w_alu_ctl = ALU_AND;
          4'b0110: w_alu_ctl = ALU_OR;
          default: w_alu_ctl = ALU_ADD;
        endcase
      end
      default: w_alu_ctl = ALU_ADD;
    endcase
  end

  assign w_alu_b = alusrc ? w_imm : w_rs2_data;

  always_comb begin
    w_alu_res = '0;
    case (w_alu_ctl)
      ALU_ADD: w_alu_res = w_rs1_data + w_alu_b;
      ALU_SUB: w_alu_res = w_rs1_data - w_alu_b;
      ALU_AND: w_alu_res = w_rs1_data & w_alu_b;
      ALU_OR:  w_alu_res = w_rs1_data | w_alu_b;
      default: w_alu_res = '0;
    endcase
  end

  assign aluz = (w_alu_res == '0);

  // Byte offset bits are dropped and high address bits wrap.
  assign w_dmem_addr  = w_alu_res[DA+1:2];
  assign w_dmem_rdata = memread ? r_dmem[w_dmem_addr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= '0;
    end else if (memwrite) begin
      r_dmem[w_dmem_addr] <= w_rs2_data;
    end
  end

  assign w_rddata  = memtoreg ? w_dmem_rdata : w_alu_res;
  assign w_pc_next = (branch && aluz) ? PC + w_imm_b : PC + XLEN'(4);

  always_ff @(posedge clk) begin
    if (!rst) PC <= '0;
    else      PC <= w_pc_next;
  end
endmodule

// File: tb/tb_riscv_single_cycle.sv
// Directed program run on riscv_single_cycle with hand-computed results
// checked against probed control and datapath nets.

module tb_riscv_single_cycle;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [7:0] ctrl;

  riscv_single_cycle dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctrl = {dut.branch, dut.memread, dut.memtoreg, dut.aluop,
                 dut.memwrite, dut.alusrc, dut.regwrite};

  localparam logic [7:0] C_R    = 8'b0001_0001;
  localparam logic [7:0] C_LW   = 8'b0110_0011;
  localparam logic [7:0] C_SW   = 8'b0000_0110;
  localparam logic [7:0] C_BEQ  = 8'b1000_1000;
  localparam logic [7:0] C_NOP  = 8'b0000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;

    for (int i = 0; i < 64; i++) dut.instruction_memory.mem[i] <= 32'h0000_0000;
    #0;
    dut.instruction_memory.mem[0]  <= 32'h0000_2083; // lw  x1,0(x0)
    dut.instruction_memory.mem[1]  <= 32'h0040_2103; // lw  x2,4(x0)
    dut.instruction_memory.mem[2]  <= 32'h0020_81B3; // add x3,x1,x2
    dut.instruction_memory.mem[3]  <= 32'h4020_82B3; // sub x5,x1,x2
    dut.instruction_memory.mem[4]  <= 32'h0010_8463; // beq x1,x1,+8
    dut.instruction_memory.mem[5]  <= 32'h0000_0013; // skipped
    dut.instruction_memory.mem[6]  <= 32'h0020_F333; // and x6,x1,x2
    dut.instruction_memory.mem[7]  <= 32'h0020_E3B3; // or  x7,x1,x2
    dut.instruction_memory.mem[8]  <= 32'h0030_2223; // sw  x3,4(x0)
    dut.instruction_memory.mem[9]  <= 32'h0040_2203; // lw  x4,4(x0)
    dut.instruction_memory.mem[10] <= 32'h0020_8463; // beq x1,x2,+8
    dut.instruction_memory.mem[11] <= 32'h0020_8033; // add x0,x1,x2
    dut.instruction_memory.mem[12] <= 32'h0010_0433; // add x8,x0,x1
    dut.instruction_memory.mem[13] <= 32'hFFFF_FFFF; // illegal opcode
    dut.instruction_memory.mem[14] <= 32'h0040_2483; // lw  x9,4(x0)
    dut.instruction_memory.mem[15] <= 32'h0020_C533; // xor x10 -> add

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", dut.PC, 32'd0);
    chk("reset_inst", dut.instruction, 32'h0000_2083);

    @(negedge clk);
    dut.r_dmem[0] <= 32'd5;
    dut.r_dmem[1] <= 32'd3;
    rst = 1'b1;
    #1;
    chk("lw1_ctrl", {24'd0, ctrl}, {24'd0, C_LW});
    chk("lw1_rddata", dut.rf.rddata, 32'd5);

    step();
    chk("pc_after_lw1", dut.PC, 32'd4);
    chk("lw2_rddata", dut.rf.rddata, 32'd3);

    step();
    chk("pc_after_lw2", dut.PC, 32'd8);
    chk("add_ctrl", {24'd0, ctrl}, {24'd0, C_R});
    chk("add_rddata", dut.rf.rddata, 32'd8);

    step();
    chk("pc_after_add", dut.PC, 32'd12);
    chk("sub_ctrl", {24'd0, ctrl}, {24'd0, C_R});
    chk("sub_rddata", dut.rf.rddata, 32'd2);

    step();
    chk("pc_beq_taken", dut.PC, 32'd16);
    chk("beq_ctrl", {24'd0, ctrl}, {24'd0, C_BEQ});
    chk("beq_aluz_eq", {31'd0, dut.aluz}, 32'd1);

    step();
    chk("pc_branch_target", dut.PC, 32'd24);
    chk("and_ctrl", {24'd0, ctrl}, {24'd0, C_R});
    chk("and_rddata", dut.rf.rddata, 32'd1);

    step();
    chk("or_rddata", dut.rf.rddata, 32'd7);

    step();
    chk("pc_sw", dut.PC, 32'd32);
    chk("sw_ctrl", {24'd0, ctrl}, {24'd0, C_SW});

    step();
    chk("lw_after_sw", dut.rf.rddata, 32'd8);

    step();
    chk("pc_beq_nt", dut.PC, 32'd40);
    chk("beq_aluz_ne", {31'd0, dut.aluz}, 32'd0);

    step();
    chk("pc_not_taken", dut.PC, 32'd44);
    chk("add_x0_rddata", dut.rf.rddata, 32'd8);

    step();
    chk("x0_reads_zero", dut.rf.rddata, 32'd5);

    step();
    chk("illegal_ctrl", {24'd0, ctrl}, {24'd0, C_NOP});

    step();
    chk("pc_after_illegal", dut.PC, 32'd56);
    chk("lw_after_illegal", dut.rf.rddata, 32'd8);

    step();
    chk("other_funct_add", dut.rf.rddata, 32'd8);

    step();
    chk("pc_end", dut.PC, 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
